conv_sched: RTL and testbench

Sequencing and write-back controller for the first convolution stage. It starts `layer0`, paces its row-pair bursts with `go_down`, and buffers its dual-channel results in a FIFO. It serialises those results onto the single shared result-memory write port, channel 0 then channel 1. It sits between the external ready/busy handshake and `layer0` plus the result SRAMs.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/sched_fifo.sv | 53 +++++
 rtl/conv_sched.sv | 164 ++++++++++++++++
 tb/tb_conv_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, write-select codes and FSM states for the first
// convolution stage scheduler.
package conv_pkg;

    localparam int DW         = 19;
    localparam int OW         = 20;
    localparam int TOTAL      = 4096;
    localparam int IMG_W      = 64;
    localparam int FIFO_DEPTH = 256;
    localparam int CNT_W      = 13;
    localparam int ADDR_W     = 12;

    localparam logic [2:0] CSEL_IDLE = 3'b000;
    localparam logic [2:0] CSEL_L0C0 = 3'b001;
    localparam logic [2:0] CSEL_L0C1 = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } state_t;

    function automatic logic [OW-1:0] zext(input logic [DW-1:0] v);
        return {{(OW-DW){1'b0}}, v};
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO with asynchronous reset, combinational read of the head
// entry and a free-space count for burst pacing.
module sched_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            wdata,
    output logic [W-1:0]            rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  free
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign free    = (AW+1)'(DEPTH) - count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/conv_sched.sv
// Starts layer0, paces its row-pair bursts with go_down and serialises the
// buffered dual-channel results onto the shared result-memory write port.
//   state | meaning
//   IDLE  | waiting for ready
//   START | l0_ready held until layer0 reports busy
//   RUN   | pacing bursts while results drain
//   DONE  | last pair written; one cycle, then IDLE
module conv_sched
    import conv_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int BURST = 2 * IMG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic              err,
    input  logic              l0_busy,
    output logic              l0_ready,
    output logic              l0_go_down,
    input  logic              l0_valid,
    input  logic [DW-1:0]     l0_data_0,
    input  logic [DW-1:0]     l0_data_1,
    output logic              cwr,
    output logic [2:0]        csel,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [OW-1:0]     cdata_wr
);

    localparam int FW = $clog2(DEPTH) + 1;

    state_t            state_q, state_d;
    logic              holdoff_q, holdoff_d;
    logic              go_down_q, go_down_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  wr_idx_q, wr_idx_d;
    logic              ph_q, ph_d;
    logic              err_q, err_d;
    logic              cwr_q, cwr_d;
    logic [2:0]        csel_q, csel_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [OW-1:0]     cdata_q, cdata_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*DW-1:0]   fifo_rdata;
    logic [FW-1:0]     fifo_free;
    logic              acc_open;

    sched_fifo #(
        .W     (2 * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({l0_data_1, l0_data_0}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    assign acc_open   = (acc_q < CNT_W'(TOTAL));
    assign fifo_push  = l0_valid && !fifo_full && acc_open;

    assign busy       = (state_q != IDLE);
    assign l0_ready   = (state_q == START);
    assign l0_go_down = go_down_q;
    assign err        = err_q;
    assign cwr        = cwr_q;
    assign csel       = csel_q;
    assign caddr_wr   = caddr_q;
    assign cdata_wr   = cdata_q;

    always_comb begin
        state_d   = state_q;
        holdoff_d = holdoff_q;
        go_down_d = 1'b0;
        acc_d     = acc_q;
        wr_idx_d  = wr_idx_q;
        ph_d      = ph_q;
        err_d     = err_q;
        cwr_d     = 1'b0;
        csel_d    = CSEL_IDLE;
        caddr_d   = '0;
        cdata_d   = '0;
        fifo_pop  = 1'b0;

        if (l0_valid && !fifo_push) err_d = 1'b1;
        if (fifo_push)              acc_d = acc_q + 1'b1;

        if (ph_q) begin
            cwr_d    = 1'b1;
            csel_d   = CSEL_L0C1;
            caddr_d  = wr_idx_q[ADDR_W-1:0];
            cdata_d  = zext(fifo_rdata[2*DW-1:DW]);
            fifo_pop = 1'b1;
            wr_idx_d = wr_idx_q + 1'b1;
            ph_d     = 1'b0;
            if (state_q == RUN && wr_idx_q == CNT_W'(TOTAL - 1)) state_d = DONE;
        end else if (!fifo_empty) begin
            cwr_d   = 1'b1;
            csel_d  = CSEL_L0C0;
            caddr_d = wr_idx_q[ADDR_W-1:0];
            cdata_d = zext(fifo_rdata[DW-1:0]);
            ph_d    = 1'b1;
        end

        // Holdoff covers the cycles before layer0's registered busy reacts.
        if (state_q == RUN && !l0_busy && !holdoff_q &&
            fifo_free >= FW'(BURST) && acc_open) begin
            go_down_d = 1'b1;
            holdoff_d = 1'b1;
        end else if (l0_busy) begin
            holdoff_d = 1'b0;
        end

        case (state_q)
            IDLE:    if (ready) state_d = START;
            START:   if (l0_busy) state_d = RUN;
            RUN:     ;
            DONE: begin
                state_d   = IDLE;
                acc_d     = '0;
                wr_idx_d  = '0;
                ph_d      = 1'b0;
                holdoff_d = 1'b0;
                go_down_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            holdoff_q <= 1'b0;
            go_down_q <= 1'b0;
            acc_q     <= '0;
            wr_idx_q  <= '0;
            ph_q      <= 1'b0;
            err_q     <= 1'b0;
            cwr_q     <= 1'b0;
            csel_q    <= CSEL_IDLE;
            caddr_q   <= '0;
            cdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            holdoff_q <= holdoff_d;
            go_down_q <= go_down_d;
            acc_q     <= acc_d;
            wr_idx_q  <= wr_idx_d;
            ph_q      <= ph_d;
            err_q     <= err_d;
            cwr_q     <= cwr_d;
            csel_q    <= csel_d;
            caddr_q   <= caddr_d;
            cdata_q   <= cdata_d;
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: a layer0 stand-in drives bursts, expected
// writes are queued at push time and compared as the DUT writes them.
module tb_conv_sched;
    import conv_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              ready = 1'b0;
    logic              busy, err, l0_ready, l0_go_down, cwr;
    logic              l0_busy = 1'b0;
    logic              l0_valid = 1'b0;
    logic [DW-1:0]     l0_data_0 = '0;
    logic [DW-1:0]     l0_data_1 = '0;
    logic [2:0]        csel;
    logic [ADDR_W-1:0] caddr_wr;
    logic [OW-1:0]     cdata_wr;

    conv_sched dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .busy       (busy),
        .err        (err),
        .l0_busy    (l0_busy),
        .l0_ready   (l0_ready),
        .l0_go_down (l0_go_down),
        .l0_valid   (l0_valid),
        .l0_data_0  (l0_data_0),
        .l0_data_1  (l0_data_1),
        .cwr        (cwr),
        .csel       (csel),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [OW-1:0]     data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  n_drv = 0, n_pop = 0, n_wr = 0, last_wr_cyc = 0, pair_idx = 0;
    int  free_prev = 256;
    bit  chk_en = 1'b0;
    bit  cur_counted = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: pops the scoreboard and tracks occupancy for pacing.
    always @(negedge clk) begin : mon
        wr_t e;
        int  free_now;
        if (cwr === 1'b1) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (csel === CSEL_L0C1) n_pop++;
        end
        free_now = 256 - ((n_drv - ((l0_valid && cur_counted) ? 1 : 0)) - n_pop);
        if (chk_en) begin
            if (cwr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", cwr, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_sel", csel, e.sel);
                    chk("wr_addr", caddr_wr, e.addr);
                    chk("wr_data", cdata_wr, e.data);
                end
            end
            if (l0_go_down === 1'b1) chk("go_down_space", free_prev >= 128, 1);
        end
        free_prev = free_now;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit counted);
        l0_valid    = 1'b1;
        l0_data_0   = d0;
        l0_data_1   = d1;
        cur_counted = counted;
        if (counted) begin
            exp_q.push_back(wr_t'{sel: CSEL_L0C0, addr: ADDR_W'(pair_idx), data: zext(d0)});
            exp_q.push_back(wr_t'{sel: CSEL_L0C1, addr: ADDR_W'(pair_idx), data: zext(d1)});
            pair_idx++;
            n_drv++;
        end
        tick();
        l0_valid    = 1'b0;
        cur_counted = 1'b0;
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) push_pair(DW'($urandom), DW'($urandom), 1'b1);
    endtask

    task automatic wait_go_down(input string tag);
        int k;
        k = 0;
        while (l0_go_down !== 1'b1 && k < 2000) begin
            tick();
            k++;
        end
        chk(tag, l0_go_down, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_l0_ready", l0_ready, 0);
        chk("rst_go_down", l0_go_down, 0);
        chk("rst_cwr", cwr, 0);
        chk("rst_csel", csel, 0);
        chk("rst_caddr", caddr_wr, 0);
        chk("rst_cdata", cdata_wr, 0);
        exp_q.delete();
        n_drv = 0; n_pop = 0; n_wr = 0; pair_idx = 0;
        l0_busy = 1'b0; l0_valid = 1'b0; ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_image();
        ready = 1'b1;
        chk("idle_l0_ready", l0_ready, 0);
        tick();
        ready = 1'b0;
        chk("start_l0_ready", l0_ready, 1);
        chk("start_busy", busy, 1);
        tick();
        chk("start_l0_ready_hold", l0_ready, 1);
        l0_busy = 1'b1;
        tick();
        chk("start_l0_ready_drop", l0_ready, 0);
        chk("run_busy", busy, 1);
    endtask

    initial begin
        int pulses;
        int k;

        do_reset();
        chk_en = 1'b1;
        repeat (3) tick();
        start_image();

        // Single pair into an empty FIFO: ch0 at +2, ch1 at +3.
        push_pair(19'h12345, 19'h00001, 1'b1);
        chk("single_t1_cwr", cwr, 0);
        tick();
        chk("single_c0_cwr", cwr, 1);
        chk("single_c0_csel", csel, CSEL_L0C0);
        chk("single_c0_addr", caddr_wr, 0);
        chk("single_c0_data", cdata_wr, 20'h12345);
        tick();
        chk("single_c1_csel", csel, CSEL_L0C1);
        chk("single_c1_addr", caddr_wr, 0);
        chk("single_c1_data", cdata_wr, 20'h00001);
        tick();
        chk("single_idle_cwr", cwr, 0);

        // Oversized first burst leaves free space below BURST.
        burst(383);
        chk("burst_no_go_down_busy", l0_go_down, 0);
        l0_busy = 1'b0;
        tick();
        chk("pace_hold", l0_go_down, 0);
        wait_go_down("pace_go_down");
        pulses = 0;
        repeat (8) begin
            tick();
            if (l0_go_down === 1'b1) pulses++;
        end
        chk("holdoff_no_repeat", pulses, 0);

        for (int b = 0; b < 28; b++) begin
            l0_busy = 1'b1;
            burst(128);
            l0_busy = 1'b0;
            wait_go_down("burst_go_down");
        end
        l0_busy = 1'b1;
        burst(128);
        chk("image_err_clear", err, 0);

        push_pair(19'h7ffff, 19'h7ffff, 1'b0);
        chk("surplus_err", err, 1);
        l0_busy = 1'b0;

        pulses = 0;
        k = 0;
        while (busy === 1'b1 && k < 2000) begin
            tick();
            if (l0_go_down === 1'b1) pulses++;
            k++;
        end
        chk("busy_fall", busy, 0);
        chk("busy_fall_timing", cyc - last_wr_cyc, 1);
        chk("no_go_down_after_total", pulses, 0);
        chk("image_write_count", n_wr, 8192);
        chk("image_queue_empty", exp_q.size(), 0);

        // Reset in the middle of an image, then restart from address 0.
        start_image();
        burst(128);
        for (int b = 0; b < 6; b++) begin
            l0_busy = 1'b0;
            wait_go_down("mid_go_down");
            l0_busy = 1'b1;
            burst(128);
        end
        l0_busy = 1'b0;
        wait_go_down("mid_go_down");
        l0_busy = 1'b1;
        burst(104);
        do_reset();
        start_image();
        burst(4);
        repeat (12) tick();
        chk("restart_queue_empty", exp_q.size(), 0);
        chk("restart_write_count", n_wr, 8);

        // Overflow: push one pair per cycle against a half-rate drain.
        chk_en = 1'b0;
        for (int i = 0; i < 600; i++) begin
            push_pair(DW'(i), DW'(i + 1), 1'b0);
            if (i == 400) chk("overflow_err_before_full", err, 0);
        end
        chk("overflow_err", err, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
